// File: rtl/serial_nibble_adder_if.sv
// Request/result bundle for serial_nibble_adder: operands and start from the
// requester, busy/done and registered result back from the adder.
interface serial_nibble_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_nibble_adder.sv
// Serial adder doing one 4-bit add per clock; WIDTH/4 RUN cycles per operation.
// Define SERIAL_ADD_OVF_EN to build the two's-complement overflow flag.
module serial_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_nibble_adder_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic                 c_out_q, c_out_d;

  logic [NIBBLES-1:0][3:0] a_nib;
  logic [NIBBLES-1:0][3:0] b_nib;
  logic [WIDTH-1:0]        acc_upd;
  logic [4:0]              nib_sum;
  logic                    last_step;

  // acc_upd is the accumulator with the current nibble replaced by this step's result
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi]            = a_q[4*gi +: 4];
    assign b_nib[gi]            = b_q[4*gi +: 4];
    assign acc_upd[4*gi +: 4]   = (idx_q == IDX_W'(gi)) ? nib_sum[3:0] : acc_q[4*gi +: 4];
  end

  assign nib_sum   = {1'b0, a_nib[idx_q]} + {1'b0, b_nib[idx_q]} + {4'b0000, carry_q};
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    if (state_q == IDLE && bus.start) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.c_in;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      acc_d   = acc_upd;
      carry_d = nib_sum[4];
      idx_d   = idx_q + 1'b1;
      if (last_step) begin
        sum_d   = acc_upd;
        c_out_d = nib_sum[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // Same-signed operands giving a differently-signed result means overflow
  always_comb begin
    ovf_d = ovf_q;
    if (last_step) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_upd[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.c_out = c_out_q;
  end
endmodule
